// File: rtl/uart_rx_byte_buffer.sv
// uart_rx_byte_buffer
//   Receive-side byte buffer for the Uart8 receiver. Every completed frame
//   (rising edge of rxDone) is either stored in a synchronous FIFO (good frame)
//   or counted and discarded (rxErr). The consumer pops with rdEn and gets a
//   registered byte plus a one-cycle rdValid strobe on the next clock.
//   Bytes lost to a full FIFO and discarded error frames are tracked in
//   sticky, saturating status that clrStat clears.
//
//   Optional build macro UART_RX_BUF_IDLE_TIMEOUT_EN adds an idle timer:
//   idle rises after IDLE_CYCLES clocks in which the FIFO holds data but sees
//   neither a new frame nor a pop. Without the macro, idle is tied low.
//
// Ports
//   clk        system clock (Uart8 clock domain)
//   rstN       synchronous active-low reset
//   rxDone     Uart8 frame-complete flag, may be held high for many cycles
//   rxErr      Uart8 framing error, qualified by rxDone
//   rxByte     Uart8 received byte
//   rdEn       consumer pop request
//   clrStat    clears overflow, dropCount, errCount
//   rdData     popped byte, valid with rdValid
//   rdValid    one-cycle strobe, one cycle after an accepted pop
//   empty      FIFO holds no entries
//   full       FIFO holds DEPTH entries
//   count      number of entries held
//   overflow   sticky: a good byte was dropped because the FIFO was full
//   dropCount  saturating count of bytes dropped on overflow
//   errCount   saturating count of frames discarded for rxErr
//   idle       data waiting with no activity for IDLE_CYCLES (optional)

module uart_rx_byte_buffer #(
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 8,
  parameter int IDLE_CYCLES = 12000
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     rxDone,
  input  logic                     rxErr,
  input  logic [7:0]               rxByte,
  input  logic                     rdEn,
  input  logic                     clrStat,
  output logic [7:0]               rdData,
  output logic                     rdValid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         dropCount,
  output logic [CNT_W-1:0]         errCount,
  output logic                     idle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          rxDonePrev;

  logic cap;
  logic goodCap;
  logic errCap;
  logic popOk;
  logic wrOk;
  logic dropEv;

  // One capture per frame, however long rxDone stays high.
  assign cap     = rxDone & ~rxDonePrev;
  assign goodCap = cap & ~rxErr;
  assign errCap  = cap & rxErr;

  assign empty = (count == '0);
  assign full  = (count == FullCount);

  // A pop on an empty FIFO is ignored even if a write lands the same cycle.
  assign popOk = rdEn & ~empty;
  // When full, a same-cycle pop frees the slot the write goes into.
  assign wrOk   = goodCap & (~full | popOk);
  assign dropEv = goodCap & full & ~popOk;

  // Storage carries no reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wrOk) begin
      mem[wrPtr] <= rxByte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      rdData     <= '0;
      rdValid    <= 1'b0;
      overflow   <= 1'b0;
      dropCount  <= '0;
      errCount   <= '0;
      // Treat rxDone as already high so a frame in flight at release is skipped.
      rxDonePrev <= 1'b1;
    end else begin
      rxDonePrev <= rxDone;
      rdValid    <= popOk;
      if (popOk) begin
        rdData <= mem[rdPtr];
        rdPtr  <= rdPtr + AW'(1);
      end
      if (wrOk) begin
        wrPtr <= wrPtr + AW'(1);
      end
      count <= count + (AW+1)'(wrOk) - (AW+1)'(popOk);

      // Clear has priority; an event coinciding with it is not recorded.
      if (clrStat) begin
        overflow  <= 1'b0;
        dropCount <= '0;
        errCount  <= '0;
      end else begin
        if (dropEv) begin
          overflow <= 1'b1;
          if (dropCount != '1) begin
            dropCount <= dropCount + CNT_W'(1);
          end
        end
        if (errCap && (errCount != '1)) begin
          errCount <= errCount + CNT_W'(1);
        end
      end
    end
  end

`ifdef UART_RX_BUF_IDLE_TIMEOUT_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IdleMax = IW'(IDLE_CYCLES);

  logic [IW-1:0] idleCnt;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      idleCnt <= '0;
    end else if (cap || popOk) begin
      idleCnt <= '0;
    end else if (!empty && (idleCnt != IdleMax)) begin
      idleCnt <= idleCnt + IW'(1);
    end
  end

  assign idle = (idleCnt == IdleMax) & ~empty;
`else
  // Constant 0; IDLE_CYCLES is non-negative and only sizes the optional timer.
  assign idle = (IDLE_CYCLES < 0);
`endif

endmodule

// File: tb/tb_uart_rx_byte_buffer.sv
module tb_uart_rx_byte_buffer;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int IDLE_N = 50;
  localparam int SATMAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       rxDone = 1'b1;
  logic       rxErr = 1'b0;
  logic [7:0] rxByte = 8'h00;
  logic       rdEn = 1'b0;
  logic       clrStat = 1'b0;
  logic [7:0] rdData;
  logic       rdValid;
  logic       empty;
  logic       full;
  logic [$clog2(DEPTH):0] count;
  logic       overflow;
  logic [CNT_W-1:0] dropCount;
  logic [CNT_W-1:0] errCount;
  logic       idle;

  uart_rx_byte_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .IDLE_CYCLES(IDLE_N)) dut (
    .clk(clk), .rstN(rstN), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .rdEn(rdEn), .clrStat(clrStat), .rdData(rdData), .rdValid(rdValid),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .dropCount(dropCount), .errCount(errCount), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nValid = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte queue + status) ----------------
  logic [7:0] fifoQ[$];
  logic [7:0] expQ[$];
  bit   prevDone = 1'b1;
  bit   expValid = 1'b0;
  int   lastRd = 0;
  bit   mOvf = 1'b0;
  int   mDrop = 0;
  int   mErr = 0;
  int   idleRun = 0;
  bit   modelReady = 1'b0;

  always @(posedge clk) begin
    bit capE;
    bit popE;
    int sizeBefore;
    modelReady = 1'b1;
    if (!rstN) begin
      fifoQ.delete();
      expQ.delete();
      prevDone = 1'b1;
      expValid = 1'b0;
      lastRd   = 0;
      mOvf     = 1'b0;
      mDrop    = 0;
      mErr     = 0;
      idleRun  = 0;
    end else begin
      capE = rxDone && !prevDone;
      prevDone = rxDone;
      sizeBefore = fifoQ.size();
      popE = rdEn && (sizeBefore > 0);
      expValid = popE;
      if (popE) begin
        lastRd = fifoQ[0];
        expQ.push_back(fifoQ.pop_front());
      end
      if (capE && rxErr) begin
        if (!clrStat && mErr < SATMAX) mErr++;
      end else if (capE) begin
        if (fifoQ.size() < DEPTH) fifoQ.push_back(rxByte);
        else if (!clrStat) begin
          mOvf = 1'b1;
          if (mDrop < SATMAX) mDrop++;
        end
      end
      if (clrStat) begin
        mOvf  = 1'b0;
        mDrop = 0;
        mErr  = 0;
      end
      if (capE || popE) idleRun = 0;
      else if (sizeBefore > 0 && idleRun < IDLE_N) idleRun++;
    end
  end

  function automatic int expIdle();
`ifdef UART_RX_BUF_IDLE_TIMEOUT_EN
    return (idleRun == IDLE_N && fifoQ.size() > 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (modelReady) begin
      chk("rdValid", rdValid, expValid);
      if (rdValid) begin
        nValid++;
        if (expQ.size() == 0) chk("rdData_unexpected", 1, 0);
        else chk("rdData", rdData, expQ.pop_front());
      end else begin
        chk("rdData_hold", rdData, lastRd);
      end
      chk("count", count, fifoQ.size());
      chk("empty", empty, fifoQ.size() == 0);
      chk("full", full, fifoQ.size() == DEPTH);
      chk("overflow", overflow, mOvf);
      chk("dropCount", dropCount, mDrop);
      chk("errCount", errCount, mErr);
      chk("idle", idle, expIdle());
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit d, input bit e, input logic [7:0] b,
                     input bit rd, input bit clr);
    rxDone = d; rxErr = e; rxByte = b; rdEn = rd; clrStat = clr;
    @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b, input bit e, input bit rd);
    cyc(1'b1, e, b, rd, 1'b0);
    cyc(1'b1, e, b, rd, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, rd, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  logic [7:0] msg [20] = '{30, 24, 19, 25, 91, 77, 1, 0, 99, 15,
                           100, 128, 255, 254, 0, 10, 43, 149, 7, 2};

  initial begin
    int v0;
    // reset with rxDone held high, then release
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    rstN = 1'b1;
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rdData", rdData, 0);
    chk("rst_errCount", errCount, 0);
    chk("rst_idle", idle, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // 20-byte message consumed as it arrives
    v0 = nValid;
    for (int i = 0; i < 20; i++) frame(msg[i], 1'b0, 1'b1);
    drain(3);
    chk("msg_valids", nValid - v0, 20);
    chk("msg_count", count, 0);
    chk("msg_overflow", overflow, 0);
    chk("msg_errCount", errCount, 0);

    // long rxDone high captures once
    for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    chk("hold_count1", count, 1);
    cyc(1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    chk("hold_count2", count, 2);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drain(3);

    // overflow: 6 frames into 4 entries
    for (int i = 0; i < 6; i++) frame(8'(8'h40 + i), 1'b0, 1'b0);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", dropCount, 2);
    drain(5);
    chk("ovf_lastByte", rdData, 8'h43);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_overflow", overflow, 0);
    chk("clr_drop", dropCount, 0);

    // error frames and saturation
    frame(8'h3C, 1'b1, 1'b0);
    chk("err_count", count, 0);
    chk("err_errCount", errCount, 1);
    for (int i = 0; i < 254; i++) begin
      cyc(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("err_at_max", errCount, 255);
    frame(8'h3C, 1'b1, 1'b0);
    chk("err_saturated", errCount, 255);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // full FIFO: capture and pop in the same cycle
    for (int i = 0; i < 4; i++) frame(8'(8'h10 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    chk("fullpop_count", count, 4);
    chk("fullpop_overflow", overflow, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drain(5);
    chk("fullpop_last", rdData, 8'h77);
    // empty FIFO: capture and pop together, no bypass
    cyc(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    chk("emptypop_count", count, 1);
    chk("emptypop_valid", rdValid, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drain(2);

    // reset mid-stream with rxDone held high
    for (int i = 0; i < 3; i++) frame(8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    rstN = 1'b0;
    cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    chk("midrst_empty", empty, 1);
    chk("midrst_count", count, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h9A, 1'b0, 1'b0);
    chk("midrst_recapture", count, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drain(2);

`ifdef UART_RX_BUF_IDLE_TIMEOUT_EN
    frame(8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_set", idle, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_clear", idle, 0);
`endif

    // randomized traffic checked against the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rstN = ($urandom_range(0, 399) != 0);
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
          8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0));
    end
    rstN = 1'b1;
    drain(8);
    chk("final_empty", empty, 1);
    chk("final_scoreboard", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
